// File: rtl/roce_addr_lookup_responder.sv
// Virtual-to-physical lookup responder for RoCE request handlers: MR table by PD index, RQ table by QPN.
// Optional statistics counters enabled with `define ADDR_LOOKUP_STATS_EN.
module roce_addr_lookup_responder #(
   parameter int unsigned NUM_MR    = 256,
   parameter int unsigned NUM_QP    = 256,
   parameter logic [47:0] RQ_BUFLEN = 48'h0000_0010_0000
) (
   input  logic         clk_i,
   input  logic         aresetn_i,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic [63:0]  req_vaddr_i,
   input  logic [23:0]  req_pdidx_i,
   input  logic [15:0]  req_qpn_i,
   output logic         resp_valid_o,
   input  logic         resp_ready_i,
   output logic [63:0]  resp_paddr_o,
   output logic [63:0]  resp_base_vaddr_o,
   output logic [47:0]  resp_buflen_o,
   output logic [3:0]   resp_accesdesc_o,
   output logic [31:0]  resp_rkey_o,
   input  logic         cfg_mr_we_i,
   input  logic [23:0]  cfg_mr_idx_i,
   input  logic [188:0] cfg_mr_data_i,
   input  logic         cfg_rq_we_i,
   input  logic [111:0] cfg_rq_data_i,
   input  logic         wb_valid_i,
   input  logic [71:0]  wb_rqbufaddr_i,
   input  logic [39:0]  wb_rqpidb_i
`ifdef ADDR_LOOKUP_STATS_EN
   ,
   output logic [31:0]  stat_lookups_o,
   output logic [31:0]  stat_misses_o
`endif
);

   localparam int unsigned MR_IW = $clog2(NUM_MR);
   localparam int unsigned QP_IW = $clog2(NUM_QP);
   localparam logic [3:0]  ACC_MISS = 4'b1111;
   localparam logic [3:0]  ACC_RQ   = 4'b0001;

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

   state_t        state;
   logic          lk_is_rq;
   logic [23:0]   lk_pdidx;
   logic [15:0]   lk_qpn;

   logic [188:0]  mr_tab [NUM_MR];
   logic [63:0]   rq_buf [NUM_QP];
   logic [31:0]   rq_db  [NUM_QP];

   // Write-port decode
   logic [15:0]   cfg_rq_qpn_c, wb_buf_qpn_c, wb_db_qpn_c;
   logic          cfg_mr_ok_c, cfg_rq_ok_c, wb_buf_ok_c, wb_db_ok_c;

   assign cfg_rq_qpn_c = cfg_rq_data_i[111:96];
   assign wb_buf_qpn_c = wb_rqbufaddr_i[71:56];
   assign wb_db_qpn_c  = wb_rqpidb_i[39:24];
   assign cfg_mr_ok_c  = cfg_mr_we_i && (cfg_mr_idx_i < 24'(NUM_MR));
   assign cfg_rq_ok_c  = cfg_rq_we_i && (cfg_rq_qpn_c < 16'(NUM_QP));
   assign wb_buf_ok_c  = wb_valid_i  && (wb_buf_qpn_c < 16'(NUM_QP));
   assign wb_db_ok_c   = wb_valid_i  && (wb_db_qpn_c  < 16'(NUM_QP));

   // Table storage; cfg is written last so it wins a same-entry collision with write-back
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         for (int unsigned i = 0; i < NUM_MR; i++) mr_tab[i] <= '0;
         for (int unsigned i = 0; i < NUM_QP; i++) begin
            rq_buf[i] <= '0;
            rq_db[i]  <= '0;
         end
      end else begin
         if (cfg_mr_ok_c) mr_tab[cfg_mr_idx_i[MR_IW-1:0]] <= cfg_mr_data_i;
         if (wb_buf_ok_c) rq_buf[wb_buf_qpn_c[QP_IW-1:0]] <= 64'(wb_rqbufaddr_i[55:0]);
         if (wb_db_ok_c)  rq_db[wb_db_qpn_c[QP_IW-1:0]]   <= 32'(wb_rqpidb_i[23:0]);
         if (cfg_rq_ok_c) begin
            rq_buf[cfg_rq_qpn_c[QP_IW-1:0]] <= cfg_rq_data_i[63:0];
            rq_db[cfg_rq_qpn_c[QP_IW-1:0]]  <= cfg_rq_data_i[95:64];
         end
      end
   end

   // Lookup read path with write-first bypass of same-cycle writes
   logic          mr_in_range_c, rq_in_range_c;
   logic [188:0]  mr_entry_c;
   logic [63:0]   rq_buf_c;
   logic [31:0]   rq_db_c;

   assign mr_in_range_c = lk_pdidx < 24'(NUM_MR);
   assign rq_in_range_c = lk_qpn < 16'(NUM_QP);

   always_comb begin
      mr_entry_c = mr_tab[lk_pdidx[MR_IW-1:0]];
      rq_buf_c   = rq_buf[lk_qpn[QP_IW-1:0]];
      rq_db_c    = rq_db[lk_qpn[QP_IW-1:0]];
      if (cfg_mr_ok_c && (cfg_mr_idx_i == lk_pdidx)) mr_entry_c = cfg_mr_data_i;
      if (wb_buf_ok_c && (wb_buf_qpn_c == lk_qpn))   rq_buf_c   = 64'(wb_rqbufaddr_i[55:0]);
      if (wb_db_ok_c  && (wb_db_qpn_c  == lk_qpn))   rq_db_c    = 32'(wb_rqpidb_i[23:0]);
      if (cfg_rq_ok_c && (cfg_rq_qpn_c == lk_qpn)) begin
         rq_buf_c = cfg_rq_data_i[63:0];
         rq_db_c  = cfg_rq_data_i[95:64];
      end
   end

   // Request/response FSM with registered outputs
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state             <= IDLE;
         req_ready_o       <= 1'b1;
         resp_valid_o      <= 1'b0;
         resp_paddr_o      <= '0;
         resp_base_vaddr_o <= '0;
         resp_buflen_o     <= '0;
         resp_accesdesc_o  <= '0;
         resp_rkey_o       <= '0;
         lk_is_rq          <= 1'b0;
         lk_pdidx          <= '0;
         lk_qpn            <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  lk_is_rq    <= (req_vaddr_i == 64'd0);
                  lk_pdidx    <= req_pdidx_i;
                  lk_qpn      <= req_qpn_i;
                  req_ready_o <= 1'b0;
                  state       <= LOOKUP;
               end
            end
            LOOKUP: begin
               resp_valid_o <= 1'b1;
               state        <= RESP;
               if (lk_is_rq) begin
                  resp_base_vaddr_o <= '0;
                  if (rq_in_range_c) begin
                     resp_paddr_o     <= rq_buf_c;
                     resp_buflen_o    <= RQ_BUFLEN;
                     resp_accesdesc_o <= ACC_RQ;
                     resp_rkey_o      <= rq_db_c;
                  end else begin
                     resp_paddr_o     <= '0;
                     resp_buflen_o    <= '0;
                     resp_accesdesc_o <= ACC_MISS;
                     resp_rkey_o      <= 32'h100;
                  end
               end else if (mr_in_range_c && mr_entry_c[188]) begin
                  resp_paddr_o      <= mr_entry_c[63:0];
                  resp_base_vaddr_o <= mr_entry_c[127:64];
                  resp_buflen_o     <= mr_entry_c[175:128];
                  resp_accesdesc_o  <= mr_entry_c[187:184];
                  resp_rkey_o       <= 32'(mr_entry_c[183:176]);
               end else begin
                  resp_paddr_o      <= '0;
                  resp_base_vaddr_o <= '0;
                  resp_buflen_o     <= '0;
                  resp_accesdesc_o  <= ACC_MISS;
                  resp_rkey_o       <= 32'h100;
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  resp_valid_o <= 1'b0;
                  req_ready_o  <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               req_ready_o  <= 1'b1;
               resp_valid_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADDR_LOOKUP_STATS_EN
   // Saturating lookup and miss counters
   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         stat_lookups_o <= '0;
         stat_misses_o  <= '0;
      end else begin
         if (req_valid_i && req_ready_o && (stat_lookups_o != 32'hFFFF_FFFF))
            stat_lookups_o <= stat_lookups_o + 32'd1;
         if (resp_valid_o && resp_ready_i && (resp_accesdesc_o == ACC_MISS) &&
             (stat_misses_o != 32'hFFFF_FFFF))
            stat_misses_o <= stat_misses_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_roce_addr_lookup_responder.sv
// Scoreboard bench for roce_addr_lookup_responder: directed lookups, write-back, collision, backpressure, reset.
module tb_roce_addr_lookup_responder;

   typedef struct packed {
      logic [63:0] paddr;
      logic [63:0] base;
      logic [47:0] buflen;
      logic [3:0]  acc;
      logic [31:0] rkey;
   } resp_t;

   localparam logic [47:0] RQB = 48'h0000_0010_0000;

   logic         clk = 1'b0;
   logic         aresetn_i;
   logic         req_valid_i;
   logic         req_ready_o;
   logic [63:0]  req_vaddr_i;
   logic [23:0]  req_pdidx_i;
   logic [15:0]  req_qpn_i;
   logic         resp_valid_o;
   logic         resp_ready_i;
   logic [63:0]  resp_paddr_o;
   logic [63:0]  resp_base_vaddr_o;
   logic [47:0]  resp_buflen_o;
   logic [3:0]   resp_accesdesc_o;
   logic [31:0]  resp_rkey_o;
   logic         cfg_mr_we_i;
   logic [23:0]  cfg_mr_idx_i;
   logic [188:0] cfg_mr_data_i;
   logic         cfg_rq_we_i;
   logic [111:0] cfg_rq_data_i;
   logic         wb_valid_i;
   logic [71:0]  wb_rqbufaddr_i;
   logic [39:0]  wb_rqpidb_i;

   int    vectors = 0;
   int    miscompares = 0;
   resp_t sb[$];

   roce_addr_lookup_responder dut (
      .clk_i(clk), .aresetn_i(aresetn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_vaddr_i(req_vaddr_i), .req_pdidx_i(req_pdidx_i), .req_qpn_i(req_qpn_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_paddr_o(resp_paddr_o), .resp_base_vaddr_o(resp_base_vaddr_o),
      .resp_buflen_o(resp_buflen_o), .resp_accesdesc_o(resp_accesdesc_o),
      .resp_rkey_o(resp_rkey_o),
      .cfg_mr_we_i(cfg_mr_we_i), .cfg_mr_idx_i(cfg_mr_idx_i), .cfg_mr_data_i(cfg_mr_data_i),
      .cfg_rq_we_i(cfg_rq_we_i), .cfg_rq_data_i(cfg_rq_data_i),
      .wb_valid_i(wb_valid_i), .wb_rqbufaddr_i(wb_rqbufaddr_i), .wb_rqpidb_i(wb_rqpidb_i)
   );

   always #5 clk = ~clk;

   function automatic resp_t act_resp();
      return '{resp_paddr_o, resp_base_vaddr_o, resp_buflen_o, resp_accesdesc_o, resp_rkey_o};
   endfunction

   // Monitor: every response handshake pops one expected entry
   always @(negedge clk) begin
      if (aresetn_i && resp_valid_o && resp_ready_i) begin
         resp_t e, a;
         a = act_resp();
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_resp got %h with no outstanding request", a);
         end else begin
            e = sb.pop_front();
            if (a !== e) begin
               miscompares++;
               $display("FAIL resp got %h expected %h", a, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic mr_write(input logic [23:0] idx, input logic [188:0] d);
      @(posedge clk); #1;
      cfg_mr_we_i = 1'b1; cfg_mr_idx_i = idx; cfg_mr_data_i = d;
      @(posedge clk); #1;
      cfg_mr_we_i = 1'b0;
   endtask

   task automatic rq_init(input logic [15:0] q, input logic [31:0] db, input logic [63:0] buf_a);
      @(posedge clk); #1;
      cfg_rq_we_i = 1'b1; cfg_rq_data_i = {q, db, buf_a};
      @(posedge clk); #1;
      cfg_rq_we_i = 1'b0;
   endtask

   task automatic wb_pulse(input logic [15:0] qb, input logic [55:0] a, input logic [15:0] qd,
                           input logic [23:0] db);
      @(posedge clk); #1;
      wb_valid_i = 1'b1; wb_rqbufaddr_i = {qb, a}; wb_rqpidb_i = {qd, db};
      @(posedge clk); #1;
      wb_valid_i = 1'b0;
   endtask

   // Issue one request; checks the two-cycle latency. collide drives cfg+wb on qpn 3 in LOOKUP.
   task automatic issue(input logic [63:0] va, input logic [23:0] pd, input logic [15:0] q,
                        input resp_t exp, input bit collide, input bit hold);
      int  n = 0;
      logic lk_valid;
      sb.push_back(exp);
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_vaddr_i = va; req_pdidx_i = pd; req_qpn_i = q;
      forever begin
         @(negedge clk);
         if (req_ready_o) break;
         n++;
         if (n > 50) begin
            miscompares++; vectors++;
            $display("FAIL accept_timeout got ready=0 expected ready=1");
            break;
         end
      end
      @(posedge clk); #1;
      if (!hold) req_valid_i = 1'b0;
      if (collide) begin
         cfg_rq_we_i = 1'b1; cfg_rq_data_i = {16'd3, 32'h55, 64'hA000_0000};
         wb_valid_i = 1'b1; wb_rqbufaddr_i = {16'd3, 56'h9020_0000}; wb_rqpidb_i = {16'd3, 24'd7};
      end
      @(negedge clk);
      lk_valid = resp_valid_o;
      @(posedge clk); #1;
      cfg_rq_we_i = 1'b0; wb_valid_i = 1'b0;
      @(negedge clk);
      check("latency", {62'd0, lk_valid, resp_valid_o}, 64'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk); n++;
      end
      if (sb.size() != 0) begin
         miscompares++; vectors++;
         $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic lookup(input logic [63:0] va, input logic [23:0] pd, input logic [15:0] q,
                         input resp_t exp);
      issue(va, pd, q, exp, 1'b0, 1'b0);
      drain();
   endtask

   resp_t mr5_hit, miss, rq_oor;
   resp_t cap;
   bit    stable;

   initial begin
      mr5_hit = '{64'h8000_0000, 64'h1000, 48'd4096, 4'b0010, 32'hA5};
      miss    = '{64'd0, 64'd0, 48'd0, 4'b1111, 32'h100};
      rq_oor  = miss;
      aresetn_i = 1'b0; req_valid_i = 1'b0; req_vaddr_i = '0; req_pdidx_i = '0; req_qpn_i = '0;
      resp_ready_i = 1'b1; cfg_mr_we_i = 1'b0; cfg_mr_idx_i = '0; cfg_mr_data_i = '0;
      cfg_rq_we_i = 1'b0; cfg_rq_data_i = '0; wb_valid_i = 1'b0; wb_rqbufaddr_i = '0; wb_rqpidb_i = '0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {62'd0, req_ready_o, resp_valid_o}, 64'd2);
      check("reset_paddr", resp_paddr_o, 64'd0);
      check("reset_rkey", {32'd0, resp_rkey_o}, 64'd0);
      @(posedge clk); #1 aresetn_i = 1'b1;

      // MR hit, out-of-range cfg write ignored, invalid entry, aliasing PD index
      mr_write(24'd5, {1'b1, 4'b0010, 8'hA5, 48'd4096, 64'h1000, 64'h8000_0000});
      lookup(64'h1040, 24'd5, 16'd0, mr5_hit);
      mr_write(24'h105, {1'b1, 4'b0100, 8'h3C, 48'd8, 64'h5000, 64'h6000});
      lookup(64'h1040, 24'd5, 16'd0, mr5_hit);
      lookup(64'h1040, 24'd7, 16'd0, miss);
      mr_write(24'd0, {1'b1, 4'b0100, 8'h11, 48'h20, 64'h2000, 64'h7000});
      lookup(64'h2000, 24'd0, 16'd0, '{64'h7000, 64'h2000, 48'h20, 4'b0100, 32'h11});
      lookup(64'h2000, 24'h01_0000, 16'd0, miss);
      mr_write(24'd9, {1'b0, 4'b0011, 8'h77, 48'd64, 64'h3000, 64'h4000});
      lookup(64'h3000, 24'd9, 16'd0, miss);

      // RQ lookups and write-back
      rq_init(16'd3, 32'd0, 64'h9000_0000);
      lookup(64'd0, 24'd0, 16'd3, '{64'h9000_0000, 64'd0, RQB, 4'b0001, 32'd0});
      wb_pulse(16'd3, 56'h9010_0000, 16'd3, 24'd1);
      lookup(64'd0, 24'd0, 16'd3, '{64'h9010_0000, 64'd0, RQB, 4'b0001, 32'd1});
      lookup(64'd0, 24'd0, 16'h103, rq_oor);
      wb_pulse(16'h104, 56'hDEAD_0000, 16'h104, 24'd9);
      lookup(64'd0, 24'd0, 16'd4, '{64'd0, 64'd0, RQB, 4'b0001, 32'd0});
      // independent bufaddr/db targets
      wb_pulse(16'd4, 56'hB000_0000, 16'd3, 24'd2);
      lookup(64'd0, 24'd0, 16'd4, '{64'hB000_0000, 64'd0, RQB, 4'b0001, 32'd0});
      lookup(64'd0, 24'd0, 16'd3, '{64'h9010_0000, 64'd0, RQB, 4'b0001, 32'd2});

      // Collision in LOOKUP cycle: cfg wins and is bypassed into the response
      issue(64'd0, 24'd0, 16'd3, '{64'hA000_0000, 64'd0, RQB, 4'b0001, 32'h55}, 1'b1, 1'b0);
      drain();
      lookup(64'd0, 24'd0, 16'd3, '{64'hA000_0000, 64'd0, RQB, 4'b0001, 32'h55});

      // Backpressure with request held
      resp_ready_i = 1'b0;
      issue(64'h1040, 24'd5, 16'd0, mr5_hit, 1'b0, 1'b1);
      cap = act_resp();
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (req_ready_o !== 1'b0 || resp_valid_o !== 1'b1 || act_resp() !== cap) stable = 1'b0;
      end
      check("bp_stable", {63'd0, stable}, 64'd1);
      @(posedge clk); #1;
      req_valid_i = 1'b0; resp_ready_i = 1'b1;
      drain();
      repeat (8) @(negedge clk);
      check("bp_single_resp", {63'd0, resp_valid_o}, 64'd0);

      // Reset while holding a response
      resp_ready_i = 1'b0;
      issue(64'h1040, 24'd5, 16'd0, mr5_hit, 1'b0, 1'b0);
      #2 aresetn_i = 1'b0;
      #1 check("rst_drops_valid", {63'd0, resp_valid_o}, 64'd0);
      sb.delete();
      @(posedge clk); #1 aresetn_i = 1'b1; resp_ready_i = 1'b1;
      @(negedge clk);
      check("rst_ready", {63'd0, req_ready_o}, 64'd1);
      lookup(64'h1040, 24'd5, 16'd0, miss);
      lookup(64'd0, 24'd0, 16'd3, '{64'd0, 64'd0, RQB, 4'b0001, 32'd0});

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
